lif_neuron_array: RTL and testbench
===================================

LIF_NEURON_ARRAY -- requirements
Module: lif_neuron_array

Interface
REQ-001 Parameter WIDTH, default 16: bit width of the membrane potential, current, threshold, reset potential and leak factor.
REQ-002 Parameter N_NEURONS, default 8: number of independent neurons; NIDX_W = max(1, clog2(N_NEURONS)).
REQ-003 Parameter REFRAC_W, default 4: bit width of the refractory counter.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 clear  input  1  synchronous soft clear of all neuron state.
REQ-007 leak_factor  input  WIDTH  unsigned leak fraction, leak_factor/2^WIDTH.
REQ-008 threshold  input  WIDTH  unsigned firing threshold.
REQ-009 reset_potential  input  WIDTH  potential loaded after a spike.
REQ-010 refrac_period  input  REFRAC_W  number of updates ignored after a spike.
REQ-011 in_valid  input  1  update request present.
REQ-012 in_ready  output  1  block accepts the update request.
REQ-013 in_idx  input  NIDX_W  index of the target neuron.
REQ-014 in_current  input  WIDTH  unsigned input current for this update.
REQ-015 out_valid  output  1  result present.
REQ-016 out_ready  input  1  consumer accepts the result.
REQ-017 out_idx  output  NIDX_W  neuron index of the result.
REQ-018 out_fired  output  1  neuron spiked on this update.
REQ-019 out_potential  output  WIDTH  membrane potential after the update.

Function
REQ-020 Per-neuron state SHALL be a potential v[i] (WIDTH bits) and a refractory count r[i] (REFRAC_W bits).
REQ-021 An update SHALL be accepted on a cycle with in_valid && in_ready; in_ready = !out_valid || out_ready.
REQ-022 Latency SHALL be 1 cycle: neuron state and out_* registers are written on the acceptance edge, and out_valid asserts the next cycle.
REQ-023 out_* SHALL hold stable while out_valid && !out_ready; out_valid SHALL deassert after a handshake with no new acceptance.
REQ-024 Leak term SHALL be leak = (v[i] * leak_factor) >> WIDTH, computed from a full 2*WIDTH-bit product and truncated.
REQ-025 Candidate value SHALL be sum = v[i] - leak + in_current, computed in WIDTH+1 bits and saturated to 2^WIDTH-1.
REQ-026 If r[i] != 0, the update SHALL ignore in_current, set r[i] = r[i]-1, keep v[i] = reset_potential, and give out_fired = 0.
REQ-027 If r[i] == 0 and sum >= threshold, the update SHALL give out_fired = 1, v[i] = reset_potential, r[i] = refrac_period and out_potential = reset_potential.
REQ-028 If r[i] == 0 and sum < threshold, the update SHALL give v[i] = sum, out_fired = 0 and out_potential = sum.
REQ-029 threshold = 0 SHALL cause a spike on every non-refractory update; refrac_period = 0 SHALL disable the refractory period.
REQ-030 in_idx >= N_NEURONS SHALL be accepted, SHALL modify no state, and SHALL return out_fired = 0 and out_potential = 0.
REQ-031 Back-to-back updates to the same neuron SHALL each see the state written by the previous update, with no stall.
REQ-032 clear SHALL set all v[i] = 0, r[i] = 0 and out_valid = 0, and SHALL take priority over a simultaneous acceptance, which is dropped.
REQ-033 leak_factor, threshold, reset_potential and refrac_period SHALL be sampled on the acceptance edge only.

Reset
REQ-034 On reset, the block SHALL set all v[i] = 0, r[i] = 0, out_valid = 0, out_idx = 0, out_fired = 0 and out_potential = 0 immediately, regardless of clk.
REQ-035 Reset asserted mid-stream SHALL discard any pending result; the first acceptance after release SHALL start from v = 0.

Verification
REQ-036 Use leak_factor = 3277, threshold = 30000, reset_potential = 5000, refrac_period = 0, and four updates to neuron 3 with current 10000 -> out_potential 10000, 19500, 28525, then 5000 with out_fired = 1 on the 4th update.
REQ-037 Use the same settings with refrac_period = 2: after the spike, two more updates with current 10000 -> potential 5000 and fired = 0 each; the 3rd update -> 14750 (5000 - 250 + 10000).
REQ-038 Use leak_factor = 0 and threshold = 65535, drive v = 60000, then apply current 10000 -> saturated result 65535 with out_fired = 1.
REQ-039 Interleave updates to neurons 0 and 7 with out_ready held low for 3 cycles -> outputs held stable, no update lost or duplicated, and per-neuron potentials independent.
REQ-040 Assert reset asynchronously between clock edges while out_valid = 1 -> out_valid drops immediately, and the next update with current 10000 returns 10000; test clear the same way, and send in_idx = N_NEURONS -> potential 0 with no state change.

Source files
------------

// File: rtl/lif_neuron_array.sv
// Array of leaky integrate-and-fire neurons sharing one update datapath.
// One update per accepted request; the result appears on out_* one cycle later.
module lif_neuron_array #(
  parameter  int WIDTH     = 16,
  parameter  int N_NEURONS = 8,
  parameter  int REFRAC_W  = 4,
  localparam int NIDX_W    = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clear,
  input  logic [WIDTH-1:0]    leak_factor,
  input  logic [WIDTH-1:0]    threshold,
  input  logic [WIDTH-1:0]    reset_potential,
  input  logic [REFRAC_W-1:0] refrac_period,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [NIDX_W-1:0]   in_idx,
  input  logic [WIDTH-1:0]    in_current,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [NIDX_W-1:0]   out_idx,
  output logic                out_fired,
  output logic [WIDTH-1:0]    out_potential
);

  localparam logic [NIDX_W:0]   N_LIM = N_NEURONS[NIDX_W:0];
  localparam logic [REFRAC_W-1:0] R_ONE = 1;

  logic [WIDTH-1:0]    v_q [N_NEURONS];
  logic [REFRAC_W-1:0] r_q [N_NEURONS];

  logic                accept;
  logic                idx_ok;
  logic [NIDX_W-1:0]   sel;
  logic [WIDTH-1:0]    v_cur;
  logic [REFRAC_W-1:0] r_cur;
  logic [2*WIDTH-1:0]  prod;
  logic [WIDTH-1:0]    leak;
  logic [WIDTH:0]      sum_ext;
  logic [WIDTH-1:0]    sum_sat;
  logic [WIDTH-1:0]    v_nx;
  logic [REFRAC_W-1:0] r_nx;
  logic                fire_nx;
  logic [WIDTH-1:0]    pot_nx;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign idx_ok   = {1'b0, in_idx} < N_LIM;
  assign sel      = idx_ok ? in_idx : '0;
  assign v_cur    = v_q[sel];
  assign r_cur    = r_q[sel];

  // leak never exceeds v (leak_factor < 2^WIDTH), so the subtraction cannot underflow
  assign prod    = {{WIDTH{1'b0}}, v_cur} * {{WIDTH{1'b0}}, leak_factor};
  assign leak    = prod[2*WIDTH-1:WIDTH];
  assign sum_ext = {1'b0, v_cur} - {1'b0, leak} + {1'b0, in_current};
  assign sum_sat = sum_ext[WIDTH] ? '1 : sum_ext[WIDTH-1:0];

  always_comb begin
    v_nx    = v_cur;
    r_nx    = r_cur;
    fire_nx = 1'b0;
    pot_nx  = '0;
    if (!idx_ok) begin
      pot_nx = '0;
    end else if (r_cur != '0) begin
      r_nx   = r_cur - R_ONE;
      v_nx   = reset_potential;
      pot_nx = reset_potential;
    end else if (sum_sat >= threshold) begin
      fire_nx = 1'b1;
      v_nx    = reset_potential;
      r_nx    = refrac_period;
      pot_nx  = reset_potential;
    end else begin
      v_nx   = sum_sat;
      pot_nx = sum_sat;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N_NEURONS; i++) begin
        v_q[i] <= '0;
        r_q[i] <= '0;
      end
      out_valid     <= 1'b0;
      out_idx       <= '0;
      out_fired     <= 1'b0;
      out_potential <= '0;
    end else if (clear) begin
      // a request arriving together with clear is dropped
      for (int i = 0; i < N_NEURONS; i++) begin
        v_q[i] <= '0;
        r_q[i] <= '0;
      end
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid     <= 1'b1;
      out_idx       <= in_idx;
      out_fired     <= fire_nx;
      out_potential <= pot_nx;
      if (idx_ok) begin
        v_q[sel] <= v_nx;
        r_q[sel] <= r_nx;
      end
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_lif_neuron_array.sv
// Scoreboard bench for lif_neuron_array: expected results are queued when an
// update is driven and popped when the result appears on out_*.
module tb_lif_neuron_array;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        clear = 1'b0;
  logic [15:0] leak_factor = '0;
  logic [15:0] threshold = '0;
  logic [15:0] reset_potential = '0;
  logic [3:0]  refrac_period = '0;
  logic        in_valid = 1'b0;
  logic [2:0]  in_idx = '0;
  logic [15:0] in_current = '0;
  logic        out_ready = 1'b1;

  logic        in_ready, out_valid, out_fired;
  logic [2:0]  out_idx;
  logic [15:0] out_potential;
  logic        o2_in_ready, o2_valid, o2_fired;
  logic [2:0]  o2_idx;
  logic [15:0] o2_potential;

  typedef struct packed {
    logic [2:0]  idx;
    logic        fired;
    logic [15:0] pot;
  } exp_t;

  exp_t q[$];
  exp_t q2[$];
  int n_checks = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  lif_neuron_array #(.WIDTH(16), .N_NEURONS(8), .REFRAC_W(4)) dut (
    .clk(clk), .reset(reset), .clear(clear), .leak_factor(leak_factor),
    .threshold(threshold), .reset_potential(reset_potential),
    .refrac_period(refrac_period), .in_valid(in_valid), .in_ready(in_ready),
    .in_idx(in_idx), .in_current(in_current), .out_valid(out_valid),
    .out_ready(out_ready), .out_idx(out_idx), .out_fired(out_fired),
    .out_potential(out_potential)
  );

  // Five-neuron copy so an index of N_NEURONS fits in the 3-bit index port.
  lif_neuron_array #(.WIDTH(16), .N_NEURONS(5), .REFRAC_W(4)) dut5 (
    .clk(clk), .reset(reset), .clear(clear), .leak_factor(leak_factor),
    .threshold(threshold), .reset_potential(reset_potential),
    .refrac_period(refrac_period), .in_valid(in_valid), .in_ready(o2_in_ready),
    .in_idx(in_idx), .in_current(in_current), .out_valid(o2_valid),
    .out_ready(out_ready), .out_idx(o2_idx), .out_fired(o2_fired),
    .out_potential(o2_potential)
  );

  task automatic set_cfg(input logic [15:0] lf, input logic [15:0] th,
                         input logic [15:0] rp, input logic [3:0] rf);
    leak_factor = lf; threshold = th; reset_potential = rp; refrac_period = rf;
  endtask

  task automatic test_reset();
    #2;
    n_checks++;
    if (out_valid !== 1'b0 || out_idx !== 3'd0 || out_fired !== 1'b0 || out_potential !== 16'd0)
      $display("FAIL reset_state: got v=%b idx=%0d f=%b pot=%0d, want all 0",
               out_valid, out_idx, out_fired, out_potential);
    else n_pass++;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_leak_fire();
    logic [15:0] pots [4];
    exp_t e;
    pots = '{16'd10000, 16'd19500, 16'd28525, 16'd5000};
    set_cfg(16'd3277, 16'd30000, 16'd5000, 4'd0);
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1; in_idx = 3'd3; in_current = 16'd10000;
      q.push_back(exp_t'{idx: 3'd3, fired: (k == 3), pot: pots[k]});
      @(posedge clk); #1;
      e = q.pop_front();
      n_checks++;
      if (out_valid !== 1'b1 || out_idx !== e.idx || out_fired !== e.fired || out_potential !== e.pot)
        $display("FAIL leak_fire[%0d]: got v=%b idx=%0d f=%b pot=%0d, want v=1 idx=%0d f=%b pot=%0d",
                 k, out_valid, out_idx, out_fired, out_potential, e.idx, e.fired, e.pot);
      else n_pass++;
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_refractory();
    logic [15:0] pots [7];
    logic        fires [7];
    exp_t e;
    pots  = '{16'd10000, 16'd19500, 16'd28525, 16'd5000, 16'd5000, 16'd5000, 16'd14750};
    fires = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    set_cfg(16'd3277, 16'd30000, 16'd5000, 4'd2);
    for (int k = 0; k < 7; k++) begin
      in_valid = 1'b1; in_idx = 3'd2; in_current = 16'd10000;
      q.push_back(exp_t'{idx: 3'd2, fired: fires[k], pot: pots[k]});
      @(posedge clk); #1;
      e = q.pop_front();
      n_checks++;
      if (out_valid !== 1'b1 || out_idx !== e.idx || out_fired !== e.fired || out_potential !== e.pot)
        $display("FAIL refractory[%0d]: got v=%b idx=%0d f=%b pot=%0d, want v=1 idx=%0d f=%b pot=%0d",
                 k, out_valid, out_idx, out_fired, out_potential, e.idx, e.fired, e.pot);
      else n_pass++;
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_saturation();
    logic [2:0]  idxs [4];
    logic [15:0] curs [4];
    logic [15:0] ths  [4];
    logic [15:0] rps  [4];
    logic [15:0] pots [4];
    logic        fires [4];
    exp_t e;
    // neuron 1: 60000 + 10000 saturates; neuron 4: threshold 0 fires every update
    idxs  = '{3'd1, 3'd1, 3'd4, 3'd4};
    curs  = '{16'd60000, 16'd10000, 16'd0, 16'd7};
    ths   = '{16'd65535, 16'd65535, 16'd0, 16'd0};
    rps   = '{16'd65535, 16'd65535, 16'd123, 16'd123};
    pots  = '{16'd60000, 16'd65535, 16'd123, 16'd123};
    fires = '{1'b0, 1'b1, 1'b1, 1'b1};
    for (int k = 0; k < 4; k++) begin
      set_cfg(16'd0, ths[k], rps[k], 4'd0);
      in_valid = 1'b1; in_idx = idxs[k]; in_current = curs[k];
      q.push_back(exp_t'{idx: idxs[k], fired: fires[k], pot: pots[k]});
      @(posedge clk); #1;
      e = q.pop_front();
      n_checks++;
      if (out_valid !== 1'b1 || out_idx !== e.idx || out_fired !== e.fired || out_potential !== e.pot)
        $display("FAIL saturation[%0d]: got v=%b idx=%0d f=%b pot=%0d, want v=1 idx=%0d f=%b pot=%0d",
                 k, out_valid, out_idx, out_fired, out_potential, e.idx, e.fired, e.pot);
      else n_pass++;
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    logic [2:0]  idxs [4];
    logic [15:0] curs [4];
    logic [15:0] pots [4];
    exp_t e;
    idxs = '{3'd0, 3'd7, 3'd0, 3'd7};
    curs = '{16'd10000, 16'd2000, 16'd10000, 16'd2000};
    pots = '{16'd10000, 16'd2000, 16'd19500, 16'd3900};
    set_cfg(16'd3277, 16'd30000, 16'd5000, 4'd0);
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1; in_idx = idxs[k]; in_current = curs[k];
      q.push_back(exp_t'{idx: idxs[k], fired: 1'b0, pot: pots[k]});
      @(posedge clk); #1;
      e = q.pop_front();
      n_checks++;
      if (out_valid !== 1'b1 || out_idx !== e.idx || out_fired !== e.fired || out_potential !== e.pot)
        $display("FAIL b2b[%0d]: got v=%b idx=%0d f=%b pot=%0d, want v=1 idx=%0d f=%b pot=%0d",
                 k, out_valid, out_idx, out_fired, out_potential, e.idx, e.fired, e.pot);
      else n_pass++;
      if (k == 0) begin
        // hold the consumer off for 3 cycles while the next request waits
        out_ready = 1'b0;
        in_idx = idxs[1]; in_current = curs[1];
        for (int s = 0; s < 3; s++) begin
          @(posedge clk); #1;
          n_checks++;
          if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_idx !== e.idx || out_potential !== e.pot)
            $display("FAIL stall_hold[%0d]: got v=%b rdy=%b idx=%0d pot=%0d, want v=1 rdy=0 idx=%0d pot=%0d",
                     s, out_valid, in_ready, out_idx, out_potential, e.idx, e.pot);
          else n_pass++;
        end
        out_ready = 1'b1;
      end
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (out_valid !== 1'b0 || q.size() != 0)
      $display("FAIL b2b_drain: got out_valid=%b pending=%0d, want 0 and 0", out_valid, q.size());
    else n_pass++;
  endtask

  task automatic test_async_reset();
    exp_t e;
    set_cfg(16'd3277, 16'd30000, 16'd5000, 4'd0);
    out_ready = 1'b0;
    in_valid = 1'b1; in_idx = 3'd3; in_current = 16'd10000;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n_checks++;
    if (out_valid !== 1'b1)
      $display("FAIL arst_pre: got out_valid=%b, want 1", out_valid);
    else n_pass++;
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || out_potential !== 16'd0)
      $display("FAIL arst_drop: got v=%b pot=%0d, want v=0 pot=0", out_valid, out_potential);
    else n_pass++;
    q.delete();
    @(negedge clk);
    reset = 1'b0;
    out_ready = 1'b1;
    in_valid = 1'b1; in_idx = 3'd3; in_current = 16'd10000;
    q.push_back(exp_t'{idx: 3'd3, fired: 1'b0, pot: 16'd10000});
    @(posedge clk); #1;
    in_valid = 1'b0;
    e = q.pop_front();
    n_checks++;
    if (out_valid !== 1'b1 || out_idx !== e.idx || out_fired !== e.fired || out_potential !== e.pot)
      $display("FAIL arst_after: got v=%b idx=%0d f=%b pot=%0d, want v=1 idx=%0d f=%b pot=%0d",
               out_valid, out_idx, out_fired, out_potential, e.idx, e.fired, e.pot);
    else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_clear();
    exp_t e;
    // fire neuron 3 with a refractory period, then clear must wipe both v and r
    set_cfg(16'd3277, 16'd0, 16'd5000, 4'd2);
    in_valid = 1'b1; in_idx = 3'd3; in_current = 16'd10000;
    q.push_back(exp_t'{idx: 3'd3, fired: 1'b1, pot: 16'd5000});
    @(posedge clk); #1;
    e = q.pop_front();
    n_checks++;
    if (out_valid !== 1'b1 || out_fired !== e.fired || out_potential !== e.pot)
      $display("FAIL clear_pre: got v=%b f=%b pot=%0d, want v=1 f=%b pot=%0d",
               out_valid, out_fired, out_potential, e.fired, e.pot);
    else n_pass++;
    set_cfg(16'd3277, 16'd30000, 16'd5000, 4'd0);
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0)
      $display("FAIL clear_drop: got out_valid=%b, want 0", out_valid);
    else n_pass++;
    q.push_back(exp_t'{idx: 3'd3, fired: 1'b0, pot: 16'd10000});
    @(posedge clk); #1;
    in_valid = 1'b0;
    e = q.pop_front();
    n_checks++;
    if (out_valid !== 1'b1 || out_idx !== e.idx || out_fired !== e.fired || out_potential !== e.pot)
      $display("FAIL clear_after: got v=%b idx=%0d f=%b pot=%0d, want v=1 idx=%0d f=%b pot=%0d",
               out_valid, out_idx, out_fired, out_potential, e.idx, e.fired, e.pot);
    else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_out_of_range();
    logic [2:0]  idxs [3];
    logic [15:0] ths  [3];
    logic [15:0] pots [3];
    exp_t e;
    idxs = '{3'd3, 3'd5, 3'd3};
    ths  = '{16'd30000, 16'd0, 16'd30000};
    pots = '{16'd10000, 16'd0, 16'd19500};
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    for (int k = 0; k < 3; k++) begin
      set_cfg(16'd3277, ths[k], 16'd5000, 4'd0);
      in_valid = 1'b1; in_idx = idxs[k]; in_current = 16'd10000;
      q2.push_back(exp_t'{idx: idxs[k], fired: 1'b0, pot: pots[k]});
      @(posedge clk); #1;
      e = q2.pop_front();
      n_checks++;
      if (o2_valid !== 1'b1 || o2_idx !== e.idx || o2_fired !== e.fired || o2_potential !== e.pot)
        $display("FAIL out_of_range[%0d]: got v=%b idx=%0d f=%b pot=%0d, want v=1 idx=%0d f=%b pot=%0d",
                 k, o2_valid, o2_idx, o2_fired, o2_potential, e.idx, e.fired, e.pot);
      else n_pass++;
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_leak_fire();
    test_refractory();
    test_saturation();
    test_back_to_back();
    test_async_reset();
    test_clear();
    test_out_of_range();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
